// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type, BCD constants and digit helpers for the serial BCD adder
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal correction
// Ports: x, y - BCD digits; ci - carry in; s - corrected sum digit;
//        co - decimal carry out; invalid - an input digit exceeded 9
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       invalid
);
  logic [4:0] sum;
  assign sum = {1'b0, x} + {1'b0, y} + {4'b0, ci};
  assign co = sum > {1'b0, BCD_MAX};
  assign s = co ? sum[3:0] + BCD_CORR : sum[3:0];
  assign invalid = (x > BCD_MAX) || (y > BCD_MAX);
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: runs one BCD digit adder over packed-BCD operands, LSD first, one digit per clock
// Ports: clk, rst_n (async active-low); start - request, sampled in IDLE;
//        a, b - packed BCD operands; cin - carry into digit 0;
//        sub - subtract A-B via ten's complement (present only with BCD_SUB_EN);
//        busy - operation in progress; done - one-cycle result-valid pulse;
//        result - packed BCD sum; cout - carry out of top digit; bad_digit - an input digit was >9
// Optional feature macro: BCD_SUB_EN
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                bad_digit
);
  localparam int W = 4 * DIGITS;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] a_r, b_r;
  logic carry;
  logic [3:0] a_d, b_d, y, s_d;
  logic co, invalid;
  always_comb begin
    a_d = a_r[3:0];
    b_d = b_r[3:0];
    for (int i = 1; i < DIGITS; i++) begin
      a_d = (cnt == CNT_W'(i)) ? a_r[4*i +: 4] : a_d;
      b_d = (cnt == CNT_W'(i)) ? b_r[4*i +: 4] : b_d;
    end
  end
`ifdef BCD_SUB_EN
  logic sub_r;
  // nine's complement maps every digit >9 to another digit >9, so the adder's
  // invalid flag still reflects the original B digit
  assign y = sub_r ? nines_comp(b_d) : b_d;
`else
  assign y = b_d;
`endif
  bcd_digit_add u_add (
    .x       (a_d),
    .y       (y),
    .ci      (carry),
    .s       (s_d),
    .co      (co),
    .invalid (invalid)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      bad_digit <= 1'b0;
`ifdef BCD_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r       <= a;
          b_r       <= b;
`ifdef BCD_SUB_EN
          sub_r     <= sub;
          carry     <= sub | cin;
`else
          carry     <= cin;
`endif
          result    <= '0;
          bad_digit <= 1'b0;
          cnt       <= '0;
          busy      <= 1'b1;
          state     <= ADD;
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++)
            if (cnt == CNT_W'(i)) result[4*i +: 4] <= s_d;
          carry     <= co;
          bad_digit <= bad_digit | invalid;
          cnt       <= cnt + 1'b1;
          if (cnt == CNT_W'(DIGITS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= co;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequences a single one-digit BCD adder over multi-digit packed-BCD operands, least significant digit first, one digit per clock.
- Captures operands on a start pulse, accumulates the result digit by digit with an internal carry register, then reports the result and carry with a one-cycle done pulse.
- Sits between a control or register interface and the BCD arithmetic datapath, so one digit adder serves wide operands.

Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1); operand width = 4*DIGITS.
- CNT_W, $clog2(DIGITS+1), digit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- cin  input  1  carry-in to digit 0.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result, cout and bad_digit are valid on it.
- result  output  4*DIGITS  packed BCD sum; held until the next accepted start.
- cout  output  1  decimal carry out of the top digit.
- bad_digit  output  1  some input digit was >9 in the last operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cout=0, bad_digit=0; digit counter, carry and operand registers cleared.
- IDLE: when start=1, register a, b and cin; clear result and bad_digit; counter=0; go to ADD.
- ADD: each cycle, digit adder input = (a_digit[cnt], b_digit[cnt], carry).
  - Binary sum s = a_d + b_d + carry, 5 bits.
  - If s>9: digit = (s+6)[3:0] and carry=1. Otherwise digit = s[3:0] and carry=0.
  - The digit is written to result[4*cnt +: 4].
  - If a_d>9 or b_d>9, set bad_digit (sticky for this operation). The correction rule still applies; the output value is then unspecified but deterministic.
  - cnt increments. After digit DIGITS-1, go to DONE.
- DONE: one cycle with done=1, busy=0, cout=final carry; then IDLE.
- Latency: start accepted at edge N; done high in cycle N+DIGITS+1. Back-to-back starts are accepted from the IDLE cycle after DONE.
- start while busy or in DONE: ignored, with no side effect.
- a, b and cin changes after capture: no effect on the running operation.
- Reset mid-operation: aborts immediately to reset values; no done pulse.
- DIGITS=1: ADD lasts exactly one cycle.
- Largest operation 99..9+99..9+1: result 99..9, cout=1 (at most 19 per digit, so the correction never overflows).

Optional Feature:
- Macro: BCD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, each B digit is replaced by its nine's complement (9-b_d) and the initial carry is forced to 1 (cin is ignored). The result is the ten's-complement difference A-B.
  - cout=1 means no borrow (A≥B). cout=0 means A<B and the result holds the ten's complement.
  - bad_digit is still checked on the original B digits.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package bcd_pkg holds:
  - state typedef {IDLE, ADD, DONE};
  - constants BCD_MAX=4'd9 and BCD_CORR=4'd6;
  - function nines_comp.
- One natural sub-module: bcd_digit_add, a combinational single-digit adder. Inputs x[3:0], y[3:0], ci. Outputs s[3:0], co, invalid. Instantiated once.
- The controller holds the FSM, counter, carry and operand/result registers.

Test Plan:
- a=0x1234, b=0x5678, cin=0, start -> done 5 cycles after start edge; result=0x6912, cout=0, bad_digit=0.
- a=0x9999, b=0x0001, cin=0 -> result=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> result=0x9999, cout=1.
- start pulsed again 2 cycles into a busy operation with different operands -> ignored; the original result is delivered and exactly one done pulse occurs.
- rst_n low for 1 cycle during ADD -> all outputs 0 immediately; no done; a following start of 0x0000+0x0000, cin=1 -> result=0x0001.
- a=0x00A0, b=0x0001 -> done with bad_digit=1; the next valid operation clears bad_digit.
- With BCD_SUB_EN: sub=1, a=0x0500, b=0x0123 -> result=0x0377, cout=1; sub=1, a=0x0123, b=0x0500 -> result=0x9623, cout=0.
